airlock_ctrl: RTL and testbench

Parametrised airlock sequencer that moves one person between the dry inner side and the flooded outer side. It owns its fill, drain, settle and (optionally) door-timeout timers internally. It latches arrive and leave requests and arbitrates between them. It enforces that the inner and outer doors are never commanded open together. It sits between the door/occupancy sensors and the door actuators and pump drivers.

---
 rtl/airlock_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_airlock_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/airlock_ctrl.sv
// -----------------------------------------------------------------------------
// airlock_ctrl
// Sequencer that moves one person between the dry inner side and the flooded
// outer side of an airlock. It owns the fill/drain/settle timers, latches and
// arbitrates arrive/leave requests, and drives the door and pump commands so
// that the inner and outer doors are never commanded open together.
//
// Optional feature macro: AIRLOCK_FAULT_EN
//   defined   : door-travel timeout and sensor-clash detection, latched FAULT
//   undefined : no timeout logic, FAULT unreachable, fault tied low
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous reset, active low
//   arrive_req     in   pulse: person outside wants to enter
//   leave_req      in   pulse: person inside wants to exit
//   person_present in   chamber occupied
//   inner_sw       in   inner door sensor (1 = open)
//   outer_sw       in   outer door sensor (1 = open)
//   inner_open     out  inner door open command
//   outer_open     out  outer door open command
//   filling        out  fill pump on
//   draining       out  drain pump on
//   level          out  chamber level (1 = high/filled)
//   busy           out  state is not IDLE
//   fault          out  latched fault indication
//   state          out  present state encoding
// -----------------------------------------------------------------------------
module airlock_ctrl #(
    parameter int FILL_CYCLES   = 50,
    parameter int DRAIN_CYCLES  = 50,
    parameter int SETTLE_CYCLES = 5,
    parameter int DOOR_TIMEOUT  = 100,
    parameter int TIMER_W       = 8,
    parameter int INIT_LEVEL    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive_req,
    input  logic       leave_req,
    input  logic       person_present,
    input  logic       inner_sw,
    input  logic       outer_sw,
    output logic       inner_open,
    output logic       outer_open,
    output logic       filling,
    output logic       draining,
    output logic       level,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EQ_A    = 3'd1;
    localparam logic [2:0] ST_OPEN_A  = 3'd2;
    localparam logic [2:0] ST_CLOSE_A = 3'd3;
    localparam logic [2:0] ST_EQ_B    = 3'd4;
    localparam logic [2:0] ST_OPEN_B  = 3'd5;
    localparam logic [2:0] ST_CLOSE_B = 3'd6;

    localparam logic [TIMER_W-1:0] FILL_LD   = TIMER_W'(FILL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LD  = TIMER_W'(DRAIN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic               INIT_LVL  = (INIT_LEVEL != 0) ? 1'b1 : 1'b0;

    logic [2:0]         state_q, state_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               level_q, level_d;
    // dir_q = 1 for arrive (entry = outer door, entry level = high), 0 for leave.
    // The entry level therefore equals dir_q, and the exit level is its inverse.
    logic               dir_q, dir_d;
    logic               pend_arr_q, pend_arr_d;
    logic               pend_lv_q, pend_lv_d;

    logic eff_arr_s, eff_lv_s, serve_arr_s;
    logic entry_sw_s, exit_sw_s;

    // A pulse arriving while IDLE is served on the same edge it is sampled.
    assign eff_arr_s   = pend_arr_q | arrive_req;
    assign eff_lv_s    = pend_lv_q | leave_req;
    // With both pending, serve the one needing no equalisation (high -> arrive).
    assign serve_arr_s = (eff_arr_s && eff_lv_s) ? level_q : eff_arr_s;
    assign entry_sw_s  = dir_q ? outer_sw : inner_sw;
    assign exit_sw_s   = dir_q ? inner_sw : outer_sw;

`ifdef AIRLOCK_FAULT_EN
    localparam logic [2:0]         ST_FAULT = 3'd7;
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(DOOR_TIMEOUT - 1);

    logic [TIMER_W-1:0] tmo_q, tmo_d;
    logic               door_late_s, timeout_s, sw_clash_s;

    // Commanded door not yet at its commanded position in the current state.
    always_comb begin
        door_late_s = 1'b0;
        case (state_q)
            ST_OPEN_A:  door_late_s = ~entry_sw_s;
            ST_CLOSE_A: door_late_s = entry_sw_s;
            ST_OPEN_B:  door_late_s = ~exit_sw_s;
            ST_CLOSE_B: door_late_s = exit_sw_s;
            default:    door_late_s = 1'b0;
        endcase
    end

    assign timeout_s  = door_late_s && (tmo_q == TMO_LAST);
    assign sw_clash_s = inner_sw & outer_sw;
`endif

    // Next-state, counter, level and request bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        dir_d      = dir_q;
        pend_arr_d = pend_arr_q | arrive_req;
        pend_lv_d  = pend_lv_q | leave_req;
        case (state_q)
            ST_IDLE: begin
                if (eff_arr_s || eff_lv_s) begin
                    dir_d = serve_arr_s;
                    if (serve_arr_s) begin
                        pend_arr_d = 1'b0;
                    end else begin
                        pend_lv_d = 1'b0;
                    end
                    if (level_q != serve_arr_s) begin
                        state_d = ST_EQ_A;
                        cnt_d   = serve_arr_s ? FILL_LD : DRAIN_LD;
                    end else begin
                        state_d = ST_OPEN_A;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EQ_A, ST_EQ_B: begin
                if (cnt_q == '0) begin
                    level_d = ~level_q;
                    state_d = (state_q == ST_EQ_A) ? ST_OPEN_A : ST_OPEN_B;
                end else begin
                    cnt_d = cnt_q - TIMER_W'(1);
                end
            end
            ST_OPEN_A: begin
                if (entry_sw_s && person_present) begin
                    state_d = ST_CLOSE_A;
                    cnt_d   = SETTLE_LD;
                end else begin
                    state_d = ST_OPEN_A;
                end
            end
            ST_CLOSE_A: begin
                if (entry_sw_s) begin
                    cnt_d = SETTLE_LD;
                end else if (cnt_q == '0) begin
                    state_d = ST_EQ_B;
                    // Exit level is the inverse of the entry level: arrive drains.
                    cnt_d   = dir_q ? DRAIN_LD : FILL_LD;
                end else begin
                    cnt_d = cnt_q - TIMER_W'(1);
                end
            end
            ST_OPEN_B: begin
                if (exit_sw_s && !person_present) begin
                    state_d = ST_CLOSE_B;
                    cnt_d   = SETTLE_LD;
                end else begin
                    state_d = ST_OPEN_B;
                end
            end
            ST_CLOSE_B: begin
                if (exit_sw_s) begin
                    cnt_d = SETTLE_LD;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - TIMER_W'(1);
                end
            end
`ifdef AIRLOCK_FAULT_EN
            ST_FAULT: begin
                pend_arr_d = pend_arr_q;
                pend_lv_d  = pend_lv_q;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef AIRLOCK_FAULT_EN
        if ((state_q != ST_FAULT) && (sw_clash_s || timeout_s)) begin
            state_d = ST_FAULT;
        end else begin
            state_d = state_d;
        end
        // Door-travel timer restarts on every state entry and saturates.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TIMER_W'(1);
        end
`endif
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            level_q    <= INIT_LVL;
            dir_q      <= 1'b0;
            pend_arr_q <= 1'b0;
            pend_lv_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            dir_q      <= dir_d;
            pend_arr_q <= pend_arr_d;
            pend_lv_q  <= pend_lv_d;
        end
    end

`ifdef AIRLOCK_FAULT_EN
    // Door-travel timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign fault = (state_q == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

    // Commands are decoded from registered state only; each door is driven in
    // mutually exclusive states, so both can never be open together.
    assign inner_open = ((state_q == ST_OPEN_A) && !dir_q) || ((state_q == ST_OPEN_B) && dir_q);
    assign outer_open = ((state_q == ST_OPEN_A) && dir_q) || ((state_q == ST_OPEN_B) && !dir_q);
    assign filling    = ((state_q == ST_EQ_A) && dir_q) || ((state_q == ST_EQ_B) && !dir_q);
    assign draining   = ((state_q == ST_EQ_A) && !dir_q) || ((state_q == ST_EQ_B) && dir_q);
    assign level      = level_q;
    assign busy       = (state_q != ST_IDLE);
    assign state      = state_q;

endmodule

// File: tb/tb_airlock_ctrl.sv
// Scoreboard bench for airlock_ctrl: expected state transitions (state, output
// vector, dwell of the previous state in clocks) are queued by the stimulus and
// popped by a monitor whenever the DUT presents a new state.
module tb_airlock_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arrive_req = 1'b0;
    logic leave_req = 1'b0;
    logic person_present = 1'b0;
    logic inner_sw = 1'b0;
    logic outer_sw = 1'b0;
    logic inner_open, outer_open, filling, draining, level, busy, fault;
    logic [2:0] state;

    typedef struct {
        logic [2:0] st;
        logic [6:0] outs;   // {inner, outer, fill, drain, level, busy, fault}
        int         dwell;  // clocks spent in previous state, -1 = don't care
    } exp_t;

    exp_t sb_q[$];
    bit   glitch_q[$];
    int   total = 0;
    int   bad = 0;
    bit   auto_en = 1'b1;
    bit   man_inner = 1'b0, man_outer = 1'b0, man_person = 1'b0;

    always #5 clk = ~clk;

    airlock_ctrl #(
        .FILL_CYCLES(4), .DRAIN_CYCLES(3), .SETTLE_CYCLES(2),
        .DOOR_TIMEOUT(8), .TIMER_W(8), .INIT_LEVEL(0)
    ) dut (
        .clk(clk), .reset(rst_n), .arrive_req(arrive_req), .leave_req(leave_req),
        .person_present(person_present), .inner_sw(inner_sw), .outer_sw(outer_sw),
        .inner_open(inner_open), .outer_open(outer_open), .filling(filling),
        .draining(draining), .level(level), .busy(busy), .fault(fault), .state(state)
    );

    // Environment: sensors follow commands one cycle later, person enters in
    // OPEN_A and leaves in OPEN_B; or manual values when auto_en is 0.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (auto_en) begin
                if (state == 3'd3 && glitch_q.size() > 0) inner_sw = glitch_q.pop_front();
                else inner_sw = inner_open;
                outer_sw = outer_open;
                if (state == 3'd2) person_present = 1'b1;
                else if (state == 3'd5) person_present = 1'b0;
            end else begin
                inner_sw = man_inner;
                outer_sw = man_outer;
                person_present = man_person;
            end
        end
    end

    // Monitor: on each state change pop and compare the expected transition.
    initial begin
        logic [2:0] prev;
        int         dw;
        int         idx;
        exp_t       e;
        prev = 3'd0;
        dw = 0;
        idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 3'd0;
                dw = 0;
            end else if (state == prev) begin
                dw++;
            end else begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change got state=%0d want state=%0d (no change)", state, prev);
                end else begin
                    e = sb_q.pop_front();
                    total++;
                    if ({state, inner_open, outer_open, filling, draining, level, busy, fault} !== {e.st, e.outs}) begin
                        bad++;
                        $display("FAIL chg%0d got state=%0d outs=%b want state=%0d outs=%b",
                                 idx, state, {inner_open, outer_open, filling, draining, level, busy, fault}, e.st, e.outs);
                    end
                    if (e.dwell >= 0) begin
                        total++;
                        if (dw != e.dwell) begin
                            bad++;
                            $display("FAIL dwell%0d state=%0d got=%0d want=%0d", idx, prev, dw, e.dwell);
                        end
                    end
                end
                idx++;
                prev = state;
                dw = 1;
            end
        end
    end

    task automatic push(input logic [2:0] st, input logic [6:0] o, input int d);
        exp_t e;
        e.st = st;
        e.outs = o;
        e.dwell = d;
        sb_q.push_back(e);
    endtask

    task automatic pulse(input logic arr, input logic lv);
        @(negedge clk);
        arrive_req = arr;
        leave_req = lv;
        @(negedge clk);
        arrive_req = 1'b0;
        leave_req = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic wait_drain(input string nm, input int max);
        int n = 0;
        while (sb_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s got=%0d pending transitions want=0 after %0d clocks", nm, sb_q.size(), max);
            sb_q.delete();
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max);
        int n = 0;
        while (state !== s && n < max) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (state !== s) begin
            bad++;
            $display("FAIL wait_state got=%0d want=%0d", state, s);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'({inner_open, outer_open, filling, draining, level, busy, fault}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Leave from low level: no equalisation on entry, fill 4 before outer door
        push(3'd2, 7'b1000010, -1);
        push(3'd3, 7'b0000010, 1);
        push(3'd4, 7'b0010010, 2);
        push(3'd5, 7'b0100110, 4);
        push(3'd6, 7'b0000110, 1);
        push(3'd0, 7'b0000100, 2);
        pulse(1'b0, 1'b1);
        wait_drain("leave_low", 60);
        repeat (3) @(negedge clk);

        // Simultaneous requests at high level: arrive first, leave right after
        push(3'd2, 7'b0100110, -1);
        push(3'd3, 7'b0000110, 1);
        push(3'd4, 7'b0001110, 2);
        push(3'd5, 7'b1000010, 3);
        push(3'd6, 7'b0000010, 1);
        push(3'd0, 7'b0000000, 2);
        push(3'd2, 7'b1000010, 1);
        push(3'd3, 7'b0000010, 1);
        push(3'd4, 7'b0010010, 2);
        push(3'd5, 7'b0100110, 4);
        push(3'd6, 7'b0000110, 1);
        push(3'd0, 7'b0000100, 2);
        pulse(1'b1, 1'b1);
        wait_drain("simultaneous", 120);
        repeat (3) @(negedge clk);

        // Leave from high level with an inner-door glitch during CLOSE_A
        glitch_q = '{1'b0, 1'b1, 1'b0, 1'b0};
        push(3'd1, 7'b0001110, -1);
        push(3'd2, 7'b1000010, 3);
        push(3'd3, 7'b0000010, 1);
        push(3'd4, 7'b0010010, 4);
        push(3'd5, 7'b0100110, 4);
        push(3'd6, 7'b0000110, 1);
        push(3'd0, 7'b0000100, 2);
        pulse(1'b0, 1'b1);
        wait_drain("settle_reload", 80);
        repeat (3) @(negedge clk);

        // Async reset during EQ_B with a leave request pending
        push(3'd2, 7'b0100110, -1);
        push(3'd3, 7'b0000110, 1);
        push(3'd4, 7'b0001110, 2);
        pulse(1'b1, 1'b0);
        wait_state(3'd4, 20);
        chk("eqb_draining", 32'(draining), 32'd1);
        leave_req = 1'b1;
        @(negedge clk);
        leave_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'({inner_open, outer_open, filling, draining, level, busy, fault}), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("pend_cleared", 32'(state), 32'd0);
        chk("sb_empty_rst", 32'(sb_q.size()), 32'd0);

        // Arrive from low level: fill 4 before outer door, drain 3 before inner
        push(3'd1, 7'b0010010, -1);
        push(3'd2, 7'b0100110, 4);
        push(3'd3, 7'b0000110, 1);
        push(3'd4, 7'b0001110, 2);
        push(3'd5, 7'b1000010, 3);
        push(3'd6, 7'b0000010, 1);
        push(3'd0, 7'b0000000, 2);
        pulse(1'b1, 1'b0);
        wait_drain("arrive_low", 80);
        repeat (3) @(negedge clk);

        // Outer door never opens in OPEN_A
        auto_en = 1'b0;
        man_inner = 1'b0;
        man_outer = 1'b0;
        man_person = 1'b0;
        @(negedge clk);
        push(3'd1, 7'b0010010, -1);
        push(3'd2, 7'b0100110, 4);
`ifdef AIRLOCK_FAULT_EN
        push(3'd7, 7'b0000111, 8);
        pulse(1'b1, 1'b0);
        wait_drain("door_timeout", 60);
        repeat (3) @(negedge clk);
        chk("fault_hold", 32'(state), 32'd7);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(3'd7, 7'b0000011, -1);
        man_inner = 1'b1;
        man_outer = 1'b1;
        wait_drain("sensor_clash", 10);
`else
        pulse(1'b1, 1'b0);
        wait_drain("no_fault_wait", 30);
        repeat (12) @(negedge clk);
        chk("wait_state", 32'(state), 32'd2);
        chk("wait_fault", 32'(fault), 32'd0);
        man_inner = 1'b1;
        man_outer = 1'b1;
        repeat (3) @(negedge clk);
        chk("clash_no_fault", 32'({fault, state}), 32'h2);
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_final", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
